// File: rtl/rv_bpu.sv
// -----------------------------------------------------------------------------
// rv_bpu -- branch prediction and hazard unit for the 5-stage RV32 core.
//
// IF : next-PC prediction from a tagged BTB plus a saturating-counter pattern
//      table. The index is bimodal (MODE=0) or gshare (MODE=1).
// ID : load-use hazard detection, which stalls PC and IF/ID and injects a bubble.
// EX : branch resolution, flush/redirect on a mispredict, and table, GHR and
//      performance-counter updates.
//
// Parameters
//   IDX_W  table index bits (2^IDX_W entries)
//   CNT_W  saturating counter width, 2..4
//   GHR_W  global history width, 2..IDX_W
//   MODE   0 = bimodal, 1 = gshare
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   if_pc_i                        fetch PC
//   pred_taken_o / pred_target_o   IF prediction
//   pred_ghr_o                     history snapshot carried down the pipe
//   id_instr_i                     ID instruction (rs1/rs2 fields)
//   ex_mem_read_i, ex_rd_i         EX load and its destination register
//   ex_branch_i .. ex_ghr_i        EX branch resolution and carried prediction
//   pc_write_o, if_id_write_o      stall enables (0 = hold)
//   ctrl_write_o                   0 = bubble into ID/EX
//   flush_o, redirect_pc_o         mispredict squash and corrected PC
//   perf_br_o, perf_miss_o         resolved-branch and mispredict counters
// -----------------------------------------------------------------------------
module rv_bpu #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 2,
   parameter int GHR_W = 4,
   parameter int MODE  = 1
) (
   input  logic             clk,
   input  logic             rstn,
   // IF
   input  logic [31:0]      if_pc_i,
   output logic             pred_taken_o,
   output logic [31:0]      pred_target_o,
   output logic [GHR_W-1:0] pred_ghr_o,
   // ID
   input  logic [31:0]      id_instr_i,
   input  logic             ex_mem_read_i,
   input  logic [4:0]       ex_rd_i,
   // EX
   input  logic             ex_branch_i,
   input  logic             ex_taken_i,
   input  logic [31:0]      ex_pc_i,
   input  logic [31:0]      ex_target_i,
   input  logic             ex_pred_taken_i,
   input  logic [31:0]      ex_pred_target_i,
   input  logic [GHR_W-1:0] ex_ghr_i,
   // pipeline control
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             ctrl_write_o,
   output logic             flush_o,
   output logic [31:0]      redirect_pc_o,
   // performance
   output logic [31:0]      perf_br_o,
   output logic [31:0]      perf_miss_o
);

   localparam int                 N        = 1 << IDX_W;
   localparam int                 TAG_W    = 32 - IDX_W - 2;
   localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   // ---------------------------------------------------------------------------
   // Storage. The BTB and the counters share one index.
   // ---------------------------------------------------------------------------
   logic             r_valid  [N];
   logic [TAG_W-1:0] r_tag    [N];
   logic [31:0]      r_target [N];
   logic [CNT_W-1:0] r_cnt    [N];
   logic [GHR_W-1:0] r_ghr;
   logic [31:0]      r_perf_br;
   logic [31:0]      r_perf_miss;

   // In gshare mode the history is zero-extended into the low index bits.
   function automatic logic [IDX_W-1:0] f_idx(input logic [31:0]      pc,
                                              input logic [GHR_W-1:0] ghr);
      logic [IDX_W-1:0] h;
      h = '0;
      if (MODE != 0) h[GHR_W-1:0] = ghr;
      return pc[IDX_W+1:2] ^ h;
   endfunction

   // ---------------------------------------------------------------------------
   // IF prediction
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] w_if_idx;
   logic             w_if_hit;
   logic             w_if_taken;

   assign w_if_idx   = f_idx(if_pc_i, r_ghr);
   assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == if_pc_i[31:IDX_W+2]);
   assign w_if_taken = w_if_hit && r_cnt[w_if_idx][CNT_W-1];

   // The reset clears every valid bit, so the prediction is not-taken during reset.
   assign pred_taken_o  = w_if_taken;
   assign pred_target_o = w_if_taken ? r_target[w_if_idx] : (if_pc_i + 32'd4);
   assign pred_ghr_o    = r_ghr;

   // ---------------------------------------------------------------------------
   // EX resolution
   // ---------------------------------------------------------------------------
   logic             w_mispredict;
   logic             w_flush;
   logic [IDX_W-1:0] w_up_idx;

   // A taken branch whose direction was right but whose target was wrong is
   // still a mispredict.
   assign w_mispredict = ex_branch_i &&
                         ((ex_taken_i != ex_pred_taken_i) ||
                          (ex_taken_i && (ex_target_i != ex_pred_target_i)));

   // Hold flush low during reset so the pipe is not redirected from stale EX inputs.
   assign w_flush       = w_mispredict && rstn;
   assign flush_o       = w_flush;
   assign redirect_pc_o = !w_flush   ? 32'd0 :
                          ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);

   // The update uses the history carried with the branch, not the live GHR.
   assign w_up_idx = f_idx(ex_pc_i, ex_ghr_i);

   // ---------------------------------------------------------------------------
   // Load-use hazard and stall/flush priority
   // ---------------------------------------------------------------------------
   logic w_luse;

   assign w_luse = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                   ((ex_rd_i == id_instr_i[19:15]) || (ex_rd_i == id_instr_i[24:20]));

   always_comb begin
      pc_write_o    = 1'b1;
      if_id_write_o = 1'b1;
      ctrl_write_o  = 1'b1;
      if (w_flush) begin
         // The ID instruction is on the wrong path, so ignore its hazard and let
         // the redirect through.
         ctrl_write_o = 1'b0;
      end else if (w_luse) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         ctrl_write_o  = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // State update. Reads above see the pre-edge contents, so a same-cycle IF
   // read of the entry being written returns the old value.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= CNT_INIT;
         end
         r_ghr       <= '0;
         r_perf_br   <= '0;
         r_perf_miss <= '0;
      end else if (ex_branch_i) begin
         if (ex_taken_i) begin
            if (r_cnt[w_up_idx] != CNT_MAX) r_cnt[w_up_idx] <= r_cnt[w_up_idx] + 1'b1;
            // A tag conflict overwrites the entry. The counter is aliased and
            // keeps its value.
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= ex_pc_i[31:IDX_W+2];
            r_target[w_up_idx] <= ex_target_i;
         end else begin
            if (r_cnt[w_up_idx] != '0) r_cnt[w_up_idx] <= r_cnt[w_up_idx] - 1'b1;
         end
         r_ghr     <= (r_ghr << 1) | GHR_W'(ex_taken_i);
         r_perf_br <= r_perf_br + 32'd1;
         if (w_mispredict) r_perf_miss <= r_perf_miss + 32'd1;
      end
   end

   assign perf_br_o   = r_perf_br;
   assign perf_miss_o = r_perf_miss;

   // Byte-offset PC bits and the non-register instruction fields are not needed.
   logic w_unused;
   assign w_unused = ^{if_pc_i[1:0], ex_pc_i[1:0], id_instr_i[31:25], id_instr_i[14:0]};

endmodule

// File: tb/tb_rv_bpu.sv
// -----------------------------------------------------------------------------
// tb_rv_bpu -- directed scoreboard bench for rv_bpu.
// Instance 0 is bimodal and instance 1 is gshare. Stimulus pushes the expected
// output values for the current cycle. A monitor pops them on the falling edge
// and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_rv_bpu;

   localparam int S_PT = 0, S_PTG = 1, S_FL = 2, S_RD = 3, S_PW = 4,
                  S_IW = 5, S_CW = 6, S_BR = 7, S_MS = 8, S_GH = 9;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] if_pc    [2];
   logic [31:0] id_instr [2];
   logic        mem_rd   [2];
   logic [4:0]  ex_rd    [2];
   logic        ex_br    [2];
   logic        ex_tk    [2];
   logic [31:0] ex_pc    [2];
   logic [31:0] ex_tgt   [2];
   logic        ex_ptk   [2];
   logic [31:0] ex_ptgt  [2];
   logic [3:0]  ex_ghr   [2];

   logic        pred_tk  [2];
   logic [31:0] pred_tgt [2];
   logic [3:0]  pred_ghr [2];
   logic        pc_w     [2];
   logic        ifid_w   [2];
   logic        ctrl_w   [2];
   logic        flush    [2];
   logic [31:0] redir    [2];
   logic [31:0] perf_br  [2];
   logic [31:0] perf_ms  [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      rv_bpu #(.IDX_W(4), .CNT_W(2), .GHR_W(4), .MODE(g)) u_dut (
         .clk              (clk),
         .rstn             (rstn),
         .if_pc_i          (if_pc[g]),
         .pred_taken_o     (pred_tk[g]),
         .pred_target_o    (pred_tgt[g]),
         .pred_ghr_o       (pred_ghr[g]),
         .id_instr_i       (id_instr[g]),
         .ex_mem_read_i    (mem_rd[g]),
         .ex_rd_i          (ex_rd[g]),
         .ex_branch_i      (ex_br[g]),
         .ex_taken_i       (ex_tk[g]),
         .ex_pc_i          (ex_pc[g]),
         .ex_target_i      (ex_tgt[g]),
         .ex_pred_taken_i  (ex_ptk[g]),
         .ex_pred_target_i (ex_ptgt[g]),
         .ex_ghr_i         (ex_ghr[g]),
         .pc_write_o       (pc_w[g]),
         .if_id_write_o    (ifid_w[g]),
         .ctrl_write_o     (ctrl_w[g]),
         .flush_o          (flush[g]),
         .redirect_pc_o    (redir[g]),
         .perf_br_o        (perf_br[g]),
         .perf_miss_o      (perf_ms[g])
      );
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          cyc;
      int          d;
      int          sig;
      logic [31:0] v;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] get(int d, int s);
      case (s)
         S_PT:    return {31'd0, pred_tk[d]};
         S_PTG:   return pred_tgt[d];
         S_FL:    return {31'd0, flush[d]};
         S_RD:    return redir[d];
         S_PW:    return {31'd0, pc_w[d]};
         S_IW:    return {31'd0, ifid_w[d]};
         S_CW:    return {31'd0, ctrl_w[d]};
         S_BR:    return perf_br[d];
         S_MS:    return perf_ms[d];
         default: return {28'd0, pred_ghr[d]};
      endcase
   endfunction

   exp_t        e;
   logic [31:0] act;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e   = q.pop_front();
         act = get(e.d, e.sig);
         n_chk++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", e.nm, e.d, cyc, act, e.v);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(int d, int s, logic [31:0] v, string nm);
      exp_t t;
      t.cyc = cyc; t.d = d; t.sig = s; t.v = v; t.nm = nm;
      q.push_back(t);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic br(int d, logic b, logic tk, logic [31:0] pc, logic [31:0] tgt,
                     logic ptk, logic [31:0] ptgt, logic [3:0] g);
      ex_br[d] = b; ex_tk[d] = tk; ex_pc[d] = pc; ex_tgt[d] = tgt;
      ex_ptk[d] = ptk; ex_ptgt[d] = ptgt; ex_ghr[d] = g;
   endtask

   // Gshare trace for an alternating T/N branch at 0x40 (index = GHR).
   logic [3:0] gs_ghr [10] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};
   logic       gs_pt  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int wait_cyc;
      logic o;
      rstn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         if_pc[d] = 32'h100; id_instr[d] = '0; mem_rd[d] = 1'b0; ex_rd[d] = '0;
         br(d, 0, 0, 0, 0, 0, 0, 0);
      end
      tick();

      // Reset: a mispredict-looking EX input must not flush or update anything.
      br(0, 1, 1, 32'h100, 32'h80, 0, 32'h104, 0);
      chk(0, S_PT, 0, "rst_ptk");      chk(0, S_PTG, 32'h104, "rst_ptgt");
      chk(0, S_BR, 0, "rst_perf_br");  chk(0, S_FL, 0, "rst_flush");
      chk(0, S_RD, 0, "rst_redirect"); chk(0, S_PW, 1, "rst_pc_write");
      tick();
      br(0, 0, 0, 0, 0, 0, 0, 0);
      rstn = 1'b1;
      chk(0, S_BR, 0, "rst_no_update"); chk(0, S_PT, 0, "rst_no_btb");
      tick();

      // Bimodal: taken to 0x80, twice.
      br(0, 1, 1, 32'h100, 32'h80, 0, 32'h104, 0);
      chk(0, S_FL, 1, "t1_flush"); chk(0, S_RD, 32'h80, "t1_redirect");
      chk(0, S_PT, 0, "t1_pre_update_read");
      chk(0, S_CW, 0, "t1_ctrl_write"); chk(0, S_PW, 1, "t1_pc_write");
      tick();
      chk(0, S_BR, 1, "t2_perf_br"); chk(0, S_MS, 1, "t2_perf_miss");
      chk(0, S_PT, 1, "t2_ptk");     chk(0, S_PTG, 32'h80, "t2_ptgt");
      chk(0, S_FL, 1, "t2_flush");
      tick();
      br(0, 0, 0, 0, 0, 0, 0, 0);
      chk(0, S_PT, 1, "idle_ptk"); chk(0, S_PTG, 32'h80, "idle_ptgt");
      chk(0, S_BR, 2, "idle_perf_br"); chk(0, S_MS, 2, "idle_perf_miss");
      chk(0, S_FL, 0, "idle_flush"); chk(0, S_RD, 0, "idle_redirect");
      tick();

      // Three not-taken outcomes that were predicted taken: counter 3 -> 0.
      for (int k = 0; k < 3; k++) begin
         br(0, 1, 0, 32'h100, 32'h80, 1, 32'h80, 0);
         chk(0, S_FL, 1, "nt_flush"); chk(0, S_RD, 32'h104, "nt_redirect");
         tick();
      end
      // Correctly predicted not-taken. The counter stays saturated at 0.
      br(0, 1, 0, 32'h100, 32'h80, 0, 32'h104, 0);
      chk(0, S_FL, 0, "nt4_flush"); chk(0, S_PT, 0, "nt4_ptk");
      chk(0, S_PTG, 32'h104, "nt4_ptgt");
      tick();
      br(0, 1, 1, 32'h100, 32'h80, 0, 32'h104, 0);   // counter 0 -> 1
      chk(0, S_FL, 1, "tk_a_flush");
      tick();
      chk(0, S_PT, 0, "sat0_still_nt");               // counter 1: not taken
      chk(0, S_FL, 1, "tk_b_flush");
      tick();                                         // counter 1 -> 2

      // Right direction but wrong target.
      br(0, 1, 1, 32'h100, 32'h200, 1, 32'h80, 0);
      chk(0, S_PT, 1, "tgt_ptk"); chk(0, S_PTG, 32'h80, "tgt_ptgt_old");
      chk(0, S_FL, 1, "tgt_flush"); chk(0, S_RD, 32'h200, "tgt_redirect");
      chk(0, S_MS, 7, "tgt_miss_pre"); chk(0, S_BR, 8, "tgt_br_pre");
      tick();
      br(0, 1, 1, 32'h100, 32'h200, 1, 32'h200, 0);
      chk(0, S_MS, 8, "tgt_miss_inc"); chk(0, S_BR, 9, "tgt_br_inc");
      chk(0, S_PTG, 32'h200, "btb_new_target"); chk(0, S_FL, 0, "good_pred_flush");
      tick();

      // Load-use hazard.
      br(0, 0, 0, 0, 0, 0, 0, 0);
      mem_rd[0] = 1'b1; ex_rd[0] = 5'd5; id_instr[0] = 32'h0050_0000;  // rs2 = x5
      chk(0, S_PW, 0, "luse_rs2_pcw"); chk(0, S_IW, 0, "luse_rs2_ifid");
      chk(0, S_CW, 0, "luse_rs2_ctrl"); chk(0, S_BR, 10, "luse_perf_br");
      tick();
      id_instr[0] = 32'h0002_8000;                                   // rs1 = x5
      chk(0, S_PW, 0, "luse_rs1_pcw");
      tick();
      ex_rd[0] = 5'd0; id_instr[0] = 32'h0;                          // x0
      chk(0, S_PW, 1, "x0_pcw"); chk(0, S_IW, 1, "x0_ifid"); chk(0, S_CW, 1, "x0_ctrl");
      tick();
      ex_rd[0] = 5'd5; id_instr[0] = 32'h0050_0000;
      br(0, 1, 1, 32'h100, 32'h80, 0, 32'h104, 0);
      chk(0, S_PW, 1, "flush_luse_pcw"); chk(0, S_IW, 1, "flush_luse_ifid");
      chk(0, S_CW, 0, "flush_luse_ctrl"); chk(0, S_FL, 1, "flush_luse_flush");
      tick();
      mem_rd[0] = 1'b0;
      br(0, 0, 0, 0, 0, 0, 0, 0);

      // Gshare: alternating T/N at 0x40. Mispredicts stop after warm-up.
      if_pc[1] = 32'h40;
      for (int k = 0; k < 10; k++) begin
         o = (k % 2 == 0);
         br(1, 1, o, 32'h40, 32'h80, gs_pt[k], gs_pt[k] ? 32'h80 : 32'h44, gs_ghr[k]);
         chk(1, S_PT, {31'd0, gs_pt[k]}, "gs_ptk");
         chk(1, S_GH, {28'd0, gs_ghr[k]}, "gs_ghr");
         chk(1, S_PTG, gs_pt[k] ? 32'h80 : 32'h44, "gs_ptgt");
         chk(1, S_FL, {31'd0, gs_pt[k] ^ o}, "gs_flush");
         tick();
      end
      br(1, 0, 0, 0, 0, 0, 0, 0);
      chk(1, S_BR, 10, "gs_perf_br"); chk(1, S_MS, 3, "gs_perf_miss");
      chk(1, S_PT, 1, "gs_pre_reset_ptk");
      tick();

      // Reset asserted mid-cycle takes effect without a clock edge.
      rstn = 1'b0;
      chk(1, S_PT, 0, "mid_rst_ptk"); chk(1, S_BR, 0, "mid_rst_br");
      chk(1, S_MS, 0, "mid_rst_miss"); chk(1, S_GH, 0, "mid_rst_ghr");
      chk(0, S_BR, 0, "mid_rst_br0"); chk(1, S_PTG, 32'h44, "mid_rst_ptgt");
      tick();
      rstn = 1'b1;
      tick();
      chk(1, S_PT, 0, "post_rst_ptk"); chk(1, S_GH, 0, "post_rst_ghr");
      tick();

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 20) begin
         tick();
         wait_cyc++;
      end
      if (q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d pending, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/rv_bpu.md
# rv_bpu

Parametrised branch prediction and hazard unit for the 5-stage RV32 core. It serves three stages. In IF it gives a next-PC prediction from a tagged BTB and saturating-counter pattern table, selectable as bimodal or gshare. In ID it detects load-use hazards. In EX it resolves branches, raises flush/redirect on a mispredict, and keeps performance counters.

## Interface
Parameters:
- IDX_W, 4: table index bits; tables hold 2^IDX_W entries.
- CNT_W, 2: saturating counter width (2..4).
- GHR_W, 4: global history width; must be <= IDX_W.
- MODE, 1: 0 = bimodal (index = pc[IDX_W+1:2]); 1 = gshare (index = pc[IDX_W+1:2] ^ zero-extended GHR).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- if_pc_i  in  32  PC of the instruction being fetched
- pred_taken_o  out  1  predict taken
- pred_target_o  out  32  predicted next PC
- pred_ghr_o  out  GHR_W  GHR snapshot used for this prediction; carried down the pipe
- id_instr_i  in  32  instruction in ID
- ex_mem_read_i  in  1  EX instruction is a load
- ex_rd_i  in  5  EX destination register
- ex_branch_i  in  1  EX holds a valid conditional branch or jal
- ex_taken_i  in  1  resolved direction
- ex_pc_i  in  32  branch PC
- ex_target_i  in  32  resolved target
- ex_pred_taken_i  in  1  prediction carried from IF
- ex_pred_target_i  in  32  predicted target carried from IF
- ex_ghr_i  in  GHR_W  GHR snapshot carried from IF
- pc_write_o  out  1  PC enable; 0 = stall
- if_id_write_o  out  1  IF/ID enable; 0 = stall
- ctrl_write_o  out  1  0 = inject bubble into ID/EX
- flush_o  out  1  squash IF/ID and ID/EX contents
- redirect_pc_o  out  32  corrected PC, valid when flush_o = 1
- perf_br_o  out  32  resolved branch count
- perf_miss_o  out  32  mispredict count

## Operation
- Tables per entry: valid (1), tag = pc[31:IDX_W+2], target (32), counter (CNT_W).
- BTB and counters use the same index: the MODE formula applied to the PC.
- Predict (combinational):
  - hit = valid & tag match.
  - pred_taken_o = hit & counter MSB.
  - pred_target_o = target when pred_taken_o = 1, else if_pc_i+4.
  - pred_ghr_o = GHR.
- Mispredict (combinational):
  - mispredict = ex_branch_i & ((ex_taken_i != ex_pred_taken_i) | (ex_taken_i & ex_target_i != ex_pred_target_i)).
  - flush_o = mispredict.
  - redirect_pc_o = ex_target_i when ex_taken_i = 1, else ex_pc_i+4.
  - redirect_pc_o = 0 when flush_o = 0.
- Update on each posedge with ex_branch_i = 1:
  - Counter is indexed with ex_pc_i and ex_ghr_i. It increments on taken, saturating at 2^CNT_W-1, and decrements on not-taken, saturating at 0.
  - On taken, the BTB entry is written: valid = 1, tag, target = ex_target_i.
  - On not-taken, the BTB entry is left unchanged.
  - GHR <= {GHR[GHR_W-2:0], ex_taken_i}. The GHR is non-speculative.
  - perf_br_o increments, as does perf_miss_o if mispredict. Both wrap modulo 2^32.
- Load-use hazard:
  - luse = ex_mem_read_i & (ex_rd_i != 0) & (ex_rd_i == id_instr_i[19:15] | ex_rd_i == id_instr_i[24:20]).
  - x0 never stalls.
- Control priority:
  - flush_o = 1: pc_write_o = 1, if_id_write_o = 1, ctrl_write_o = 0. Flush beats luse, because the ID instruction is wrong-path.
  - Else luse: pc_write_o = 0, if_id_write_o = 0, ctrl_write_o = 0.
  - Else all three = 1.

## Timing
- Prediction has zero-cycle latency from if_pc_i. Flush, redirect and stall outputs have zero-cycle latency from EX/ID inputs.
- Table, GHR and perf updates are visible from the cycle after the resolving edge.
- A same-cycle IF read of an entry being updated returns the pre-update value.
- Reset (asynchronous, also mid-operation):
  - All valid = 0.
  - Counters = 2^(CNT_W-1)-1 (weakly not-taken).
  - GHR = 0, perf counters = 0.
- Outputs during reset:
  - pred_taken_o = 0.
  - pred_target_o = if_pc_i+4.
  - flush_o = 0, redirect_pc_o = 0.
  - Stall outputs follow the combinational rules: all 1 when no load-use hazard is present.
- A BTB tag conflict replaces the old entry. The counter is shared (aliasing is allowed) and is not reset on replacement.

## Test plan
- Reset, then if_pc_i = 0x100 -> pred_taken_o = 0, pred_target_o = 0x104, perf_br_o = 0.
- MODE = 0. Branch at 0x100 resolved taken to 0x80, twice. First resolve: flush_o = 1, redirect_pc_o = 0x80. Then if_pc_i = 0x100 -> pred_taken_o = 1, pred_target_o = 0x80. Then not-taken three times -> counter saturates at 0 and prediction is not-taken.
- Taken branch correctly predicted but with ex_target_i = 0x200 != ex_pred_target_i = 0x80 -> flush_o = 1, redirect_pc_o = 0x200, perf_miss_o increments.
- ex_mem_read_i = 1, ex_rd_i = 5, id_instr_i rs2 = 5 -> pc_write_o = if_id_write_o = ctrl_write_o = 0. Same with ex_rd_i = 0 -> no stall. Same with a concurrent mispredict -> pc_write_o = 1, ctrl_write_o = 0, flush_o = 1.
- MODE = 1, GHR_W = 4: an alternating T/N branch at 0x40 reaches zero mispredicts after warm-up. Assert rstn low mid-run -> all predictions not-taken, perf counters read 0.
